// File: rtl/mau_pkg.sv
// Shared definitions for mem_access_unit: default widths, FSM states, latched request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mau_pkg;

  localparam int DEF_DATA_W = 19;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_TAG_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Request as captured on the accept edge; ea is the wrapped effective address.
  typedef struct packed {
    logic                  write;
    logic [DEF_DATA_W-1:0] ea;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/mau_perf_counters.sv
// Saturating load/store/error event counters for mem_access_unit (MAU_PERF_CNT_EN builds).
// Latency: count visible the cycle after the increment pulse.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module mau_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_load,
  input  logic             inc_store,
  input  logic             inc_err,
  output logic [CNT_W-1:0] perf_loads,
  output logic [CNT_W-1:0] perf_stores,
  output logic [CNT_W-1:0] perf_errs
);

  // Count each event class independently, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else begin
      if (inc_load  && (perf_loads  != '1)) perf_loads  <= perf_loads  + 1'b1;
      if (inc_store && (perf_stores != '1)) perf_stores <= perf_stores + 1'b1;
      if (inc_err   && (perf_errs   != '1)) perf_errs   <= perf_errs   + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: ea = base + offset, bounds check, one memory strobe, tagged response.
// Latency: accept edge to resp_valid is 3 edges (load), 2 (store), 1 (out of range).
// Backpressure: single transaction in flight; req_ready stays low until the response is taken.
// Optional: define MAU_PERF_CNT_EN to add perf_loads/perf_stores/perf_errs counters.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_base,
  input  logic [DATA_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MAU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_loads,
  output logic [15:0]       perf_stores,
  output logic [15:0]       perf_errs
`endif
);

  state_e            state;
  req_t              req_q;
  logic [DATA_W-1:0] ea;
  logic              accept;
  logic              ea_err;

  // Sum is truncated to DATA_W bits on purpose: a two's-complement offset wraps back into range.
  assign ea        = req_base + req_offset;
  assign ea_err    = (ea >= DATA_W'(DEPTH));
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Memory-side address/data and echoed response fields come straight from the request register.
  assign mem_addr   = req_q.ea;
  assign mem_wdata  = req_q.wdata;
  assign resp_write = req_q.write;
  assign resp_tag   = req_q.tag;

  // Sequencer: accept, strobe memory for one cycle, wait out the read latency, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.write <= req_write;
            req_q.tag   <= req_tag;
            if (ea_err) begin
              // Out-of-range: answer at once, leave the memory address bus untouched.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= RESP;
            end else begin
              req_q.ea    <= ea;
              req_q.wdata <= req_wdata;
              mem_write   <= req_write;
              mem_read    <= !req_write;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          resp_err  <= 1'b0;
          if (req_q.write) begin
            resp_data  <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Memory output register was loaded on the ISSUE edge.
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAU_PERF_CNT_EN
  mau_perf_counters #(
    .CNT_W(16)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_load   (accept && !ea_err && !req_write),
    .inc_store  (accept && !ea_err && req_write),
    .inc_err    (accept && ea_err),
    .perf_loads (perf_loads),
    .perf_stores(perf_stores),
    .perf_errs  (perf_errs)
  );
`endif

endmodule
